multi_delay_timer: RTL and testbench

Multi-channel programmable delay timer. Each of NUM_CH independent channels takes a trigger input, a 2-bit mode and a weighted delay count, and drives an active-low delay output. A per-channel prescaler sets the time base. The block sits between the trigger sources and downstream enables. It replaces single-channel timer instances, and adds retrigger, delay-on and delay-off modes plus status outputs.

---
 rtl/multi_delay_timer_if.sv | 22 ++
 rtl/multi_delay_timer.sv | 109 ++++++++++
 tb/tb_multi_delay_timer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_delay_timer_if.sv
// multi_delay_timer_if: trigger/config inputs and per-channel status outputs of the delay timer
interface multi_delay_timer_if #(
    parameter int NUM_CH = 4,
    parameter int WEIGHT_BIT_WIDTH = 8,
    parameter int PRESCALE_WIDTH = 8
);
    logic [NUM_CH-1:0] trigger_in;
    logic [2*NUM_CH-1:0] mode;
    logic [NUM_CH*WEIGHT_BIT_WIDTH-1:0] weighted_bits;
    logic [PRESCALE_WIDTH-1:0] prescale_div;
    logic [NUM_CH-1:0] delay_out_n;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] expired;
    modport master (
        output trigger_in, mode, weighted_bits, prescale_div,
        input delay_out_n, busy, expired
    );
    modport slave (
        input trigger_in, mode, weighted_bits, prescale_div,
        output delay_out_n, busy, expired
    );
endinterface

// File: rtl/multi_delay_timer.sv
// multi_delay_timer: independent delay channels with one-shot, retrigger, delay-on and delay-off modes
module multi_delay_timer #(
    parameter int NUM_CH = 4,
    parameter int WEIGHT_BIT_WIDTH = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input logic clk,
    input logic rst,
    multi_delay_timer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, HOLD} state_t;
    localparam logic [1:0] ONE_SHOT = 2'b00;
    localparam logic [1:0] RETRIG = 2'b01;
    localparam logic [1:0] DELAY_ON = 2'b10;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t st, nxt;
        logic trig_q, out_n, busy_q, exp_q;
        logic [1:0] mode_q, m_in;
        logic [WEIGHT_BIT_WIDTH-1:0] w_q, w_in, cnt;
        logic [PRESCALE_WIDTH-1:0] pc;
        logic trig, rise, fall, counting, tick, expire, load, exp_evt;
        assign trig = bus.trigger_in[i];
        assign rise = trig & ~trig_q;
        assign fall = ~trig & trig_q;
        assign m_in = bus.mode[2*i +: 2];
        assign w_in = bus.weighted_bits[i*WEIGHT_BIT_WIDTH +: WEIGHT_BIT_WIDTH];
        // ACTIVE only counts in the one-shot modes; delay modes count in WAIT/HOLD
        assign counting = (st == ACTIVE && !mode_q[1]) || st == WAIT || st == HOLD;
        assign tick = counting && pc >= bus.prescale_div;
        assign expire = tick && cnt == WEIGHT_BIT_WIDTH'(1);
        always_comb begin
            nxt = st;
            load = 1'b0;
            exp_evt = 1'b0;
            case (st)
                IDLE:
                    case (m_in)
                        ONE_SHOT, RETRIG: if (rise && w_in != '0) begin
                            nxt = ACTIVE;
                            load = 1'b1;
                        end
                        DELAY_ON: if (rise) begin
                            nxt = (w_in == '0) ? ACTIVE : WAIT;
                            load = 1'b1;
                        end
                        default: if (trig) nxt = ACTIVE;
                    endcase
                WAIT:
                    if (!trig) nxt = IDLE;
                    else if (expire) begin
                        nxt = ACTIVE;
                        exp_evt = 1'b1;
                    end
                ACTIVE:
                    if (mode_q == DELAY_ON) begin
                        if (!trig) nxt = IDLE;
                    end else if (mode_q[1]) begin
                        if (fall) begin
                            nxt = (w_q == '0) ? IDLE : HOLD;
                            load = 1'b1;
                        end
                    end else if (mode_q == RETRIG && rise) load = 1'b1;
                    else if (expire) begin
                        nxt = IDLE;
                        exp_evt = 1'b1;
                    end
                default:
                    if (trig) nxt = ACTIVE;
                    else if (expire) begin
                        nxt = IDLE;
                        exp_evt = 1'b1;
                    end
            endcase
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                st <= IDLE;
                trig_q <= 1'b0;
                mode_q <= '0;
                w_q <= '0;
                cnt <= '0;
                pc <= '0;
                out_n <= 1'b1;
                busy_q <= 1'b0;
                exp_q <= 1'b0;
            end else begin
                st <= nxt;
                trig_q <= trig;
                out_n <= !(nxt == ACTIVE || nxt == HOLD);
                busy_q <= nxt != IDLE;
                exp_q <= exp_evt;
                if (st == IDLE) begin
                    mode_q <= m_in;
                    w_q <= w_in;
                end
                if (load) begin
                    cnt <= (st == IDLE) ? w_in : w_q;
                    pc <= '0;
                end else if (counting) begin
                    cnt <= tick ? cnt - 1'b1 : cnt;
                    pc <= tick ? '0 : pc + 1'b1;
                end
            end
        end
        assign bus.delay_out_n[i] = out_n;
        assign bus.busy[i] = busy_q;
        assign bus.expired[i] = exp_q;
    end
endmodule

// File: tb/tb_multi_delay_timer.sv
// tb_multi_delay_timer: directed literal checks plus randomized run against a deadline-based channel model
module tb_multi_delay_timer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    multi_delay_timer_if #(.NUM_CH(4), .WEIGHT_BIT_WIDTH(8), .PRESCALE_WIDTH(8)) bus();
    multi_delay_timer #(.NUM_CH(4), .WEIGHT_BIT_WIDTH(8), .PRESCALE_WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    int total = 0;
    int passed = 0;
    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask
    // Model phases: output high & counting to assertion, output low & counting to release, low without counting
    localparam int IDL = 0, DELAY = 1, PULSE = 2, LEVEL = 3, TAIL = 4;
    int ph[4];
    longint dl[4];
    logic [1:0] lm[4];
    int lw[4];
    logic prev[4];
    longint now = 0;
    logic [3:0] m_out_n = 4'hF, m_busy = 4'h0, m_exp = 4'h0;
    logic chk_en = 1'b0;
    logic tr, rise, fall, hit, e;
    logic [1:0] mi;
    int wi, pd;
    always @(posedge clk) begin
        now++;
        pd = int'(bus.prescale_div) + 1;
        for (int c = 0; c < 4; c++) begin
            tr = bus.trigger_in[c];
            rise = tr & ~prev[c];
            fall = ~tr & prev[c];
            mi = bus.mode[2*c +: 2];
            wi = int'(bus.weighted_bits[8*c +: 8]);
            hit = (now == dl[c]);
            e = 1'b0;
            if (rst) begin
                ph[c] = IDL;
                prev[c] = 1'b0;
            end else begin
                case (ph[c])
                    IDL: begin
                        lm[c] = mi;
                        lw[c] = wi;
                        if (!mi[1] && rise && wi != 0) begin
                            ph[c] = PULSE;
                            dl[c] = now + wi * pd;
                        end else if (mi == 2'b10 && rise) begin
                            ph[c] = (wi == 0) ? LEVEL : DELAY;
                            dl[c] = now + wi * pd;
                        end else if (mi == 2'b11 && tr) ph[c] = LEVEL;
                    end
                    PULSE:
                        if (lm[c] == 2'b01 && rise) dl[c] = now + lw[c] * pd;
                        else if (hit) begin
                            ph[c] = IDL;
                            e = 1'b1;
                        end
                    DELAY:
                        if (!tr) ph[c] = IDL;
                        else if (hit) begin
                            ph[c] = LEVEL;
                            e = 1'b1;
                        end
                    LEVEL:
                        if (lm[c] == 2'b10) begin
                            if (!tr) ph[c] = IDL;
                        end else if (fall) begin
                            ph[c] = (lw[c] == 0) ? IDL : TAIL;
                            dl[c] = now + lw[c] * pd;
                        end
                    default:
                        if (tr) ph[c] = LEVEL;
                        else if (hit) begin
                            ph[c] = IDL;
                            e = 1'b1;
                        end
                endcase
                prev[c] = tr;
            end
            m_out_n[c] = !(ph[c] == PULSE || ph[c] == LEVEL || ph[c] == TAIL);
            m_busy[c] = ph[c] != IDL;
            m_exp[c] = e;
        end
        chk_en = 1'b1;
    end
    always @(negedge clk) if (chk_en) begin
        check("delay_out_n", 32'(bus.delay_out_n), 32'(m_out_n));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("expired", 32'(bus.expired), 32'(m_exp));
    end
    int lows[4], exps[4], busys[4];
    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            lows[c] = 0;
            exps[c] = 0;
            busys[c] = 0;
        end
    endtask
    task automatic tick_n(int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (!bus.delay_out_n[c]) lows[c]++;
                if (bus.expired[c]) exps[c]++;
                if (bus.busy[c]) busys[c]++;
            end
        end
    endtask
    task automatic setch(int c, logic [1:0] m, logic [7:0] w);
        bus.mode[2*c +: 2] = m;
        bus.weighted_bits[8*c +: 8] = w;
    endtask
    task automatic pulse_pair(int c, int gap);
        bus.trigger_in[c] = 1'b1;
        tick_n(1);
        bus.trigger_in[c] = 1'b0;
        tick_n(gap);
        bus.trigger_in[c] = 1'b1;
        tick_n(1);
        bus.trigger_in[c] = 1'b0;
        tick_n(25);
    endtask
    initial begin
        rst = 1'b1;
        bus.trigger_in = '0;
        bus.mode = '0;
        bus.weighted_bits = '0;
        bus.prescale_div = '0;
        clr();
        tick_n(2);
        check("rst_out_n", 32'(bus.delay_out_n), 32'hF);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_expired", 32'(bus.expired), 32'h0);
        rst = 1'b0;
        tick_n(1);
        setch(0, 2'b00, 8'd10);
        clr();
        bus.trigger_in[0] = 1'b1;
        tick_n(1);
        bus.trigger_in[0] = 1'b0;
        tick_n(4);
        setch(0, 2'b01, 8'd50);
        bus.trigger_in[0] = 1'b1;
        tick_n(1);
        bus.trigger_in[0] = 1'b0;
        tick_n(20);
        check("oneshot_low", lows[0], 10);
        check("oneshot_exp", exps[0], 1);
        check("oneshot_others", lows[1] + lows[2] + lows[3] + busys[1], 0);
        setch(0, 2'b01, 8'd10);
        clr();
        pulse_pair(0, 5);
        check("retrig_low", lows[0], 16);
        check("retrig_exp", exps[0], 1);
        setch(0, 2'b01, 8'd6);
        clr();
        pulse_pair(0, 5);
        check("retrig_coincide_low", lows[0], 12);
        check("retrig_coincide_exp", exps[0], 1);
        bus.prescale_div = 8'd3;
        setch(1, 2'b10, 8'd10);
        clr();
        bus.trigger_in[1] = 1'b1;
        tick_n(20);
        bus.trigger_in[1] = 1'b0;
        tick_n(5);
        check("delayon_short_low", lows[1], 0);
        check("delayon_short_exp", exps[1], 0);
        clr();
        bus.trigger_in[1] = 1'b1;
        tick_n(60);
        bus.trigger_in[1] = 1'b0;
        tick_n(5);
        check("delayon_long_low", lows[1], 20);
        check("delayon_long_exp", exps[1], 1);
        bus.prescale_div = 8'd1;
        setch(2, 2'b11, 8'd5);
        clr();
        bus.trigger_in[2] = 1'b1;
        tick_n(8);
        bus.trigger_in[2] = 1'b0;
        tick_n(20);
        check("delayoff_low", lows[2], 18);
        check("delayoff_exp", exps[2], 1);
        clr();
        bus.trigger_in[2] = 1'b1;
        tick_n(4);
        bus.trigger_in[2] = 1'b0;
        tick_n(3);
        bus.trigger_in[2] = 1'b1;
        tick_n(4);
        bus.trigger_in[2] = 1'b0;
        tick_n(20);
        check("delayoff_retrig_low", lows[2], 21);
        check("delayoff_retrig_exp", exps[2], 1);
        bus.prescale_div = 8'd0;
        setch(3, 2'b00, 8'd200);
        bus.trigger_in[3] = 1'b1;
        tick_n(50);
        rst = 1'b1;
        tick_n(1);
        check("midrst_out_n", 32'(bus.delay_out_n), 32'hF);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        clr();
        tick_n(210);
        check("midrst_restart_low", lows[3], 200);
        check("midrst_restart_exp", exps[3], 1);
        bus.trigger_in[3] = 1'b0;
        tick_n(2);
        for (int m = 0; m < 4; m++) begin
            setch(m, 2'(m), 8'd0);
            clr();
            bus.trigger_in[m] = 1'b1;
            tick_n(5);
            bus.trigger_in[m] = 1'b0;
            tick_n(3);
            check("w0_low", lows[m], (m < 2) ? 0 : 5);
            check("w0_busy", busys[m], (m < 2) ? 0 : 5);
            check("w0_exp", exps[m], 0);
        end
        for (int s = 0; s < 4; s++) begin
            rst = 1'b1;
            bus.prescale_div = 8'($urandom_range(0, 3));
            tick_n(2);
            rst = 1'b0;
            for (int k = 0; k < 1500; k++) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 7) == 0) bus.trigger_in[c] = ~bus.trigger_in[c];
                    if ($urandom_range(0, 15) == 0) setch(c, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)));
                end
                rst = ($urandom_range(0, 599) == 0);
                tick_n(1);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
